ultrasonic_echo_emulator: RTL and testbench

- Emulates the sensor side of the HC-SR04-style ultrasonic protocol: accepts the trigger pulse driven by the ranging circuit and returns an echo pulse whose width encodes a programmed distance in cm.
- Used for hardware-in-loop bring-up in place of the physical sensor on the JB header, and in simulation benches for the ranging path.
- Distance comes from switches or the bench, 6-bit cm, matching the system distance width.

---
 rtl/ultrasonic_echo_emulator_if.sv | 30 +++
 rtl/ultrasonic_echo_emulator.sv | 156 +++++++++++++++
 tb/tb_ultrasonic_echo_emulator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_echo_emulator_if.sv
// Signal bundle between a ranging circuit and the ultrasonic echo emulator.
//   trig         : trigger pulse from the ranging circuit (asynchronous to clock)
//   enable       : 1 = emulator answers triggers
//   distance_cm  : emulated distance in cm, 0 = out of range
//   echo         : echo pulse back to the ranging circuit
//   busy         : emulator is in delay, echo or cooldown
//   short_trig   : one-cycle flag, trigger too short
//   ignored_trig : one-cycle flag, trigger rising edge arrived while busy
//   meas_count   : completed echoes, wrapping
// master = ranging-circuit side, slave = emulator side.
interface ultrasonic_echo_emulator_if;
    logic       trig;
    logic       enable;
    logic [5:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       short_trig;
    logic       ignored_trig;
    logic [7:0] meas_count;

    modport master (
        output trig, enable, distance_cm,
        input  echo, busy, short_trig, ignored_trig, meas_count
    );

    modport slave (
        input  trig, enable, distance_cm,
        output echo, busy, short_trig, ignored_trig, meas_count
    );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// Sensor-side emulation of an HC-SR04-style ultrasonic ranger. A valid trigger pulse
// (at least MIN_TRIG_CYCLES wide) is answered, DELAY_CYCLES after its falling edge,
// with an echo pulse of distance_cm * CM_CYCLES cycles (TIMEOUT_CYCLES when the
// distance is 0), followed by COOLDOWN_CYCLES of dead time.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : emulator side of ultrasonic_echo_emulator_if (trig/enable/distance_cm in,
//           echo/busy/short_trig/ignored_trig/meas_count out, all outputs registered)
module ultrasonic_echo_emulator #(
    parameter int unsigned CM_CYCLES       = 2900,
    parameter int unsigned MIN_TRIG_CYCLES = 500,
    parameter int unsigned DELAY_CYCLES    = 25000,
    parameter int unsigned TIMEOUT_CYCLES  = 1900000,
    parameter int unsigned COOLDOWN_CYCLES = 500000
) (
    input logic                        clock,
    input logic                        reset,
    ultrasonic_echo_emulator_if.slave  bus
);

    localparam int unsigned CntW = 22;
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t MinLen     = cnt_t'(MIN_TRIG_CYCLES);
    localparam cnt_t DelayLast  = cnt_t'(DELAY_CYCLES - 1);
    localparam cnt_t CoolLast   = cnt_t'(COOLDOWN_CYCLES - 1);
    localparam cnt_t TimeoutLen = cnt_t'(TIMEOUT_CYCLES);
    localparam cnt_t CmLen      = cnt_t'(CM_CYCLES);

    typedef enum logic [2:0] {StIdle, StTrig, StDelay, StEcho, StCooldown} state_e;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [5:0] dist_q, dist_d;
    logic [7:0] meas_q, meas_d;
    logic       echo_q, echo_d;
    logic       busy_q, busy_d;
    logic       short_q, short_d;
    logic       ign_q, ign_d;
    logic       trig_meta_q, trig_s_q, trig_prev_q;

    logic trig_rise, trig_fall;
    cnt_t echo_len;

    assign trig_rise = trig_s_q & ~trig_prev_q;
    assign trig_fall = ~trig_s_q & trig_prev_q;

    // 6-bit distance times CM_CYCLES fits in 22 bits for any distance.
    assign echo_len = (dist_q == 6'd0) ? TimeoutLen : cnt_t'(dist_q) * CmLen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dist_q      <= '0;
            meas_q      <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            short_q     <= 1'b0;
            ign_q       <= 1'b0;
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dist_q      <= dist_d;
            meas_q      <= meas_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            short_q     <= short_d;
            ign_q       <= ign_d;
            trig_meta_q <= bus.trig;
            trig_s_q    <= trig_meta_q;
            trig_prev_q <= trig_s_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        meas_d  = meas_q;
        short_d = 1'b0;
        ign_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Edge-triggered: a trig level left high from earlier is never accepted.
                if (trig_rise && bus.enable) begin
                    state_d = StTrig;
                    cnt_d   = '0;
                end
            end
            StTrig: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (trig_fall) begin
                    if (cnt_q >= MinLen) begin
                        dist_d  = bus.distance_cm;
                        cnt_d   = '0;
                        state_d = StDelay;
                    end else begin
                        short_d = 1'b1;
                        state_d = StIdle;
                    end
                end else if (trig_s_q && (cnt_q != MinLen)) begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StDelay: begin
                ign_d = trig_rise;
                if (cnt_q == DelayLast) begin
                    cnt_d   = '0;
                    state_d = StEcho;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StEcho: begin
                ign_d = trig_rise;
                if (cnt_q == echo_len - cnt_t'(1)) begin
                    cnt_d   = '0;
                    meas_d  = meas_q + 8'd1;
                    state_d = StCooldown;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StCooldown: begin
                ign_d = trig_rise;
                if (cnt_q == CoolLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Decoded from the next state so echo/busy register in step with state_q.
        echo_d = (state_d == StEcho);
        busy_d = (state_d inside {StDelay, StEcho, StCooldown});
    end

    assign bus.echo         = echo_q;
    assign bus.busy         = busy_q;
    assign bus.short_trig   = short_q;
    assign bus.ignored_trig = ign_q;
    assign bus.meas_count   = meas_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Self-checking bench for ultrasonic_echo_emulator with shortened timing parameters.
module tb_ultrasonic_echo_emulator;

    localparam int CM  = 10;
    localparam int MIN = 5;
    localparam int DEL = 20;
    localparam int TO  = 1000;
    localparam int CD  = 50;
    // Input flop, synchronized flop and edge-detect register between trig and the FSM.
    localparam int SYNC_LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ultrasonic_echo_emulator_if bus ();

    ultrasonic_echo_emulator #(
        .CM_CYCLES      (CM),
        .MIN_TRIG_CYCLES(MIN),
        .DELAY_CYCLES   (DEL),
        .TIMEOUT_CYCLES (TO),
        .COOLDOWN_CYCLES(CD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Echo pulse monitor: start cycle and width of every echo pulse.
    int rise_q[$];
    int width_q[$];
    bit in_e = 0;
    int w_run = 0;
    int short_cnt = 0;
    int ign_cnt = 0;
    bit busy_seen = 0;

    always @(negedge clock) begin
        if (bus.echo === 1'b1) begin
            if (!in_e) begin
                rise_q.push_back(cyc);
                in_e  = 1;
                w_run = 0;
            end
            w_run++;
        end else if (in_e) begin
            in_e = 0;
            width_q.push_back(w_run);
        end
        if (bus.short_trig === 1'b1) short_cnt++;
        if (bus.ignored_trig === 1'b1) ign_cnt++;
        if (bus.busy === 1'b1) busy_seen = 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int meas_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: echo length from the distance rule.
    function automatic int exp_width(input int d);
        return (d == 0) ? TO : d * CM;
    endfunction

    task automatic pulse(input int w, output int drop);
        @(posedge clock);
        #1 bus.trig = 1'b1;
        repeat (w) @(posedge clock);
        #1 bus.trig = 1'b0;
        drop = cyc;
    endtask

    task automatic wait_width(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (width_q.size() > 0) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_high(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.echo === 1'b1) break;
            @(negedge clock);
        end
        check({tag, "_high"}, bus.echo, 1);
    endtask

    task automatic expect_echo(input string tag, input int drop, input int d);
        bit ok;
        int r;
        int w;
        wait_width(TO + DEL + 100, ok);
        check({tag, "_seen"}, ok, 1);
        if (ok) begin
            r = rise_q.pop_front();
            w = width_q.pop_front();
            check({tag, "_rise"}, r, drop + SYNC_LAT + DEL);
            check({tag, "_width"}, w, exp_width(d));
        end
        meas_exp = (meas_exp + 1) % 256;
        check({tag, "_meas"}, bus.meas_count, meas_exp);
    endtask

    initial begin
        int drop;
        int dummy;
        int s0;
        int i0;
        int d;
        bit ok;

        bus.trig        = 1'b0;
        bus.enable      = 1'b1;
        bus.distance_cm = 6'd7;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_echo", bus.echo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_short", bus.short_trig, 0);
        check("rst_ign", bus.ignored_trig, 0);
        check("rst_meas", bus.meas_count, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Nominal
        s0 = short_cnt;
        pulse(8, drop);
        expect_echo("nominal", drop, 7);
        check("nominal_no_short", short_cnt - s0, 0);
        repeat (CD + 10) @(negedge clock);

        // Out of range and maximum distance
        bus.distance_cm = 6'd0;
        pulse(8, drop);
        expect_echo("dist0", drop, 0);
        repeat (CD + 10) @(negedge clock);
        bus.distance_cm = 6'd63;
        pulse(9, drop);
        expect_echo("dist63", drop, 63);
        repeat (CD + 10) @(negedge clock);

        // Short trigger
        bus.distance_cm = 6'd7;
        s0 = short_cnt;
        busy_seen = 0;
        pulse(3, dummy);
        repeat (40) @(negedge clock);
        check("short_pulse", short_cnt - s0, 1);
        check("short_no_echo", rise_q.size(), 0);
        check("short_no_busy", busy_seen, 0);
        check("short_meas", bus.meas_count, meas_exp);

        // Busy rejection: one trigger in ECHO, one in COOLDOWN
        i0 = ign_cnt;
        pulse(8, drop);
        wait_high("busy", DEL + 40);
        repeat (5) @(negedge clock);
        pulse(4, dummy);
        expect_echo("busy_echo", drop, 7);
        pulse(4, dummy);
        repeat (55) @(negedge clock);
        check("busy_ignored", ign_cnt - i0, 2);
        check("busy_single_echo", rise_q.size(), 0);
        pulse(8, drop);
        expect_echo("after_cool", drop, 7);
        repeat (CD + 10) @(negedge clock);

        // Distance latched at acceptance
        pulse(8, drop);
        repeat (5) @(negedge clock);
        bus.distance_cm = 6'd3;
        expect_echo("latch", drop, 7);
        repeat (CD + 10) @(negedge clock);

        // Disabled: no response
        bus.enable = 1'b0;
        busy_seen = 0;
        pulse(8, dummy);
        repeat (40) @(negedge clock);
        check("dis_no_echo", rise_q.size(), 0);
        check("dis_no_busy", busy_seen, 0);
        bus.enable = 1'b1;

        // Trig held high across COOLDOWN exit needs a fresh edge
        pulse(8, drop);
        expect_echo("hold_first", drop, 3);
        i0 = ign_cnt;
        bus.trig = 1'b1;
        repeat (CD + 30) @(negedge clock);
        bus.trig = 1'b0;
        repeat (30) @(negedge clock);
        check("hold_no_echo", rise_q.size(), 0);
        check("hold_ignored", ign_cnt - i0, 1);
        pulse(8, drop);
        expect_echo("hold_fresh", drop, 3);
        repeat (CD + 10) @(negedge clock);

        // Randomized distances and widths, with occasional short triggers
        for (int k = 0; k < 6; k++) begin
            d = $urandom_range(0, 63);
            bus.distance_cm = 6'(d);
            if ($urandom_range(0, 1) == 1) begin
                s0 = short_cnt;
                pulse($urandom_range(1, 3), dummy);
                repeat (30) @(negedge clock);
                check("rnd_short", short_cnt - s0, 1);
                check("rnd_short_no_echo", rise_q.size(), 0);
            end
            pulse($urandom_range(7, 14), drop);
            expect_echo("rnd", drop, d);
            repeat (CD + $urandom_range(5, 20)) @(negedge clock);
        end

        // Reset mid-ECHO drops echo without a clock edge
        bus.distance_cm = 6'd7;
        pulse(8, dummy);
        wait_high("rst_mid", DEL + 40);
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_echo", bus.echo, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_meas", bus.meas_count, 0);
        meas_exp = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        rise_q.delete();
        width_q.delete();
        repeat (3) @(negedge clock);
        pulse(8, drop);
        expect_echo("post_rst", drop, 7);
        repeat (CD + 10) @(negedge clock);

        // meas_count wrap
        bus.distance_cm = 6'd1;
        for (int k = 0; k < 254; k++) begin
            pulse(8, dummy);
            wait_width(DEL + CM + 40, ok);
            if (ok) begin
                void'(rise_q.pop_front());
                void'(width_q.pop_front());
            end
            meas_exp = (meas_exp + 1) % 256;
            repeat (CD + 5) @(negedge clock);
        end
        check("wrap_255", bus.meas_count, 255);
        pulse(8, drop);
        expect_echo("wrap", drop, 1);
        check("wrap_zero", bus.meas_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
